// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: binary-angle constants, arctangent table, gain
// compensation and FSM states used by the rotation and vectoring blocks.
package cordic_pkg;

    // Binary angle: 2^32 units per full turn.
    localparam logic [31:0] PI_4 = 32'h2000_0000;
    localparam logic [31:0] PI_2 = PI_4 << 1;
    localparam logic [31:0] PI   = PI_2 << 1;

    // 1/K = 0.60725 in Q2.14.
    localparam logic signed [31:0] GAIN_COMP = 32'sd9949;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREROT,
        ST_ITER,
        ST_SCALE
    } cordic_state_t;

    // atan(2^-i) in binary-angle units, rounded to nearest.
    function automatic logic [31:0] atan_lut(input logic [3:0] idx);
        logic [31:0] value;
        case (idx)
            4'd0:    value = PI_4;
            4'd1:    value = 32'h12E4_051E;
            4'd2:    value = 32'h09FB_385B;
            4'd3:    value = 32'h0511_11D4;
            4'd4:    value = 32'h028B_0D43;
            4'd5:    value = 32'h0145_D7E1;
            4'd6:    value = 32'h00A2_F61E;
            4'd7:    value = 32'h0051_7C55;
            4'd8:    value = 32'h0028_BE53;
            4'd9:    value = 32'h0014_5F2F;
            4'd10:   value = 32'h000A_2F98;
            4'd11:   value = 32'h0005_17CC;
            4'd12:   value = 32'h0002_8BE6;
            4'd13:   value = 32'h0001_45F3;
            4'd14:   value = 32'h0000_A2FA;
            default: value = 32'h0000_0000;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation, shared by rotation and vectoring.
// clockwise=1 rotates the vector by -atan(2^-i) and adds atan(2^-i) to z.
module cordic_micro_rot
    import cordic_pkg::*;
#(
    parameter int XY_WIDTH = 18
) (
    input  logic [XY_WIDTH-1:0] x,
    input  logic [XY_WIDTH-1:0] y,
    input  logic [31:0]         z,
    input  logic [3:0]          shift,
    input  logic                clockwise,
    output logic [XY_WIDTH-1:0] x_next,
    output logic [XY_WIDTH-1:0] y_next,
    output logic [31:0]         z_next
);

    logic signed [XY_WIDTH-1:0] x_sh;
    logic signed [XY_WIDTH-1:0] y_sh;
    logic [31:0]                angle;

    assign x_sh  = $signed(x) >>> shift;
    assign y_sh  = $signed(y) >>> shift;
    assign angle = atan_lut(shift);

    assign x_next = clockwise ? x + y_sh : x - y_sh;
    assign y_next = clockwise ? y - x_sh : y + x_sh;
    assign z_next = clockwise ? z + angle : z - angle;

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> magnitude and atan2 phase,
// one micro-rotation per clock, start/done handshake.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ITERATIONS  = 15,
    parameter int ANGLE_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       x_in,
    input  logic [WIDTH-1:0]       y_in,
    output logic [WIDTH-1:0]       magnitude,
    output logic [ANGLE_WIDTH-1:0] phase,
    output logic                   busy,
    output logic                   done
);

    // Two guard bits absorb -(-2^(WIDTH-1)) and the ~1.647 CORDIC gain.
    localparam int XW = WIDTH + 2;

    cordic_state_t state, state_next;

    logic signed [XW-1:0] x_r, y_r;
    logic [31:0]          z_r;
    logic [3:0]           iter;
    logic                 zero_r;
    logic [XW-1:0]        x_nx, y_nx;
    logic [31:0]          z_nx;
    logic signed [31:0]   prod;
    logic                 last_iter;

    cordic_micro_rot #(.XY_WIDTH(XW)) u_micro_rot (
        .x        (x_r),
        .y        (y_r),
        .z        (z_r),
        .shift    (iter),
        .clockwise(~y_r[XW-1]),
        .x_next   (x_nx),
        .y_next   (y_nx),
        .z_next   (z_nx)
    );

    assign last_iter = (iter == 4'(ITERATIONS - 1));
    assign prod      = 32'(x_r) * GAIN_COMP;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_PREROT;
            ST_PREROT: state_next = ST_ITER;
            ST_ITER:   if (last_iter) state_next = ST_SCALE;
            ST_SCALE:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            iter      <= '0;
            zero_r    <= 1'b0;
            magnitude <= '0;
            phase     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: default-low here makes done a single-cycle pulse without extra state.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_r  <= XW'($signed(x_in));
                        y_r  <= XW'($signed(y_in));
                        busy <= 1'b1;
                    end
                end
                ST_PREROT: begin
                    // Left half-plane: rotate by pi so iterations only see x >= 0.
                    if (x_r[XW-1]) begin
                        x_r <= -x_r;
                        y_r <= -y_r;
                        z_r <= PI;
                    end else begin
                        z_r <= '0;
                    end
                    iter   <= '0;
                    zero_r <= (x_r == '0) && (y_r == '0);
                end
                ST_ITER: begin
                    x_r  <= x_nx;
                    y_r  <= y_nx;
                    z_r  <= z_nx;
                    iter <= iter + 4'd1;
                end
                ST_SCALE: begin
                    magnitude <= zero_r ? '0 : WIDTH'(prod >>> 14);
                    phase     <= zero_r ? '0 : ANGLE_WIDTH'(z_r);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: bit-exact reference model plus
// tolerance checks against ideal atan2/sqrt for the directed vectors.
module tb_cordic_vectoring;

    localparam int    WIDTH      = 16;
    localparam int    ITERATIONS = 15;
    localparam int    LATENCY    = ITERATIONS + 2;
    localparam int    PERIOD     = ITERATIONS + 3;
    localparam real   PI_R       = 3.14159265358979323846;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x_in, y_in;
    logic [15:0] magnitude;
    logic [31:0] phase;
    logic        busy, done;

    cordic_vectoring #(.WIDTH(WIDTH), .ITERATIONS(ITERATIONS), .ANGLE_WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .x_in     (x_in),
        .y_in     (y_in),
        .magnitude(magnitude),
        .phase    (phase),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [15:0] exp_mag;
        logic [31:0] exp_phase;
        bit          ideal;
        longint      ideal_mag;
        logic [31:0] ideal_phase;
        int          acc_cycle;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cycles  = 0;
    int     last_done = -1;
    bit     stream_mode = 1'b0;
    longint atan_ref[ITERATIONS];

    always @(posedge clock) cycles <= cycles + 1;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] want, input longint tol = 0);
        logic signed [63:0] diff;
        n_tests++;
        diff = (got > want) ? got - want : want - got;
        if ($isunknown(got) || diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     tag, got, got, want, want, tol);
        end
    endtask

    // Reference: the vectoring algorithm on unbounded integers.
    function automatic void model(input int xi, input int yi,
                                  output logic [15:0] m, output logic [31:0] p);
        longint      x, y, xn, pr;
        logic [31:0] z;
        x = xi; y = yi; z = 32'h0;
        if (x < 0) begin
            x = -x; y = -y; z = 32'h8000_0000;
        end
        for (int i = 0; i < ITERATIONS; i++) begin
            if (y >= 0) begin
                xn = x + (y >>> i); y = y - (x >>> i); z = z + 32'(atan_ref[i]);
            end else begin
                xn = x - (y >>> i); y = y + (x >>> i); z = z - 32'(atan_ref[i]);
            end
            x = xn;
        end
        pr = x * 9949;
        m  = 16'(pr >>> 14);
        p  = z;
        if (xi == 0 && yi == 0) begin
            m = '0; p = '0;
        end
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drain", sb_q.size(), 0);
    endtask

    // Called at a negedge; leaves the bench at the negedge after acceptance.
    task automatic issue(input int x, input int y, input string tag,
                         input bit ideal, input bit hold_start);
        exp_t        e;
        logic [15:0] m;
        logic [31:0] p;
        wait_idle();
        x_in  = 16'(x);
        y_in  = 16'(y);
        start = 1'b1;
        model(x, y, m, p);
        e.tag         = tag;
        e.exp_mag     = m;
        e.exp_phase   = p;
        e.ideal       = ideal;
        e.ideal_mag   = longint'($sqrt(real'(longint'(x) * x + longint'(y) * y)));
        e.ideal_phase = 32'(longint'($atan2(real'(y), real'(x)) / (2.0 * PI_R) * 4294967296.0));
        e.acc_cycle   = cycles + 1;
        sb_q.push_back(e);
        @(negedge clock);
        check({tag, "_busy_after_start"}, busy, 1);
        if (!hold_start) start = 1'b0;
        x_in = 16'($urandom);
        y_in = 16'($urandom);
    endtask

    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.tag, "_mag"}, magnitude, mon_e.exp_mag);
                check({mon_e.tag, "_phase"}, phase, mon_e.exp_phase);
                check({mon_e.tag, "_latency"}, cycles - mon_e.acc_cycle, LATENCY);
                check({mon_e.tag, "_busy_low"}, busy, 0);
                if (mon_e.ideal) begin
                    check({mon_e.tag, "_mag_ideal"}, magnitude, mon_e.ideal_mag, 3);
                    check({mon_e.tag, "_phase_err"},
                          longint'($signed(phase - mon_e.ideal_phase)), 0, 32'h4_0000);
                end
                if (stream_mode && last_done >= 0)
                    check({mon_e.tag, "_gap"}, cycles - last_done, PERIOD);
                last_done = cycles;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < ITERATIONS; i++)
            atan_ref[i] = longint'($atan(1.0 / (2.0 ** i)) / (2.0 * PI_R) * 4294967296.0);

        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(negedge clock);
        check("rst_magnitude", magnitude, 0);
        check("rst_phase", phase, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clock);

        issue( 16384,      0, "pos_x",    1'b1, 1'b0);
        issue(     0,  16384, "pos_y",    1'b1, 1'b0);
        issue( 10000,  10000, "diag",     1'b1, 1'b0);
        issue(-16384,      0, "neg_x",    1'b1, 1'b0);
        issue(-32768, -32768, "min_corner", 1'b1, 1'b0);
        issue(     0,      0, "zero",     1'b0, 1'b0);
        issue( 32767, -32768, "q4_edge",  1'b1, 1'b0);
        issue(    -1,      1, "tiny",     1'b0, 1'b0);
        drain();

        // Back-to-back with start held high and inputs scrambled while busy.
        stream_mode = 1'b1;
        last_done   = -1;
        for (int j = 0; j < 5; j++)
            issue(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                  $sformatf("stream%0d", j), 1'b0, 1'b1);
        start = 1'b0;
        drain();
        stream_mode = 1'b0;

        // Reset while iteration 7 is pending: everything clears, no done.
        issue(-12345, 23456, "aborted", 1'b0, 1'b0);
        repeat (8) @(negedge clock);
        reset = 1'b1;
        void'(sb_q.pop_back());
        #1;
        check("midrst_magnitude", magnitude, 0);
        check("midrst_phase", phase, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        issue(-20000, -7000, "after_rst", 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
